// File: rtl/leve1_if_pkg.sv
// Shared definitions for the LEVE1 instruction-fetch stage.
//   XLEN / ILEN   : address and instruction widths
//   RESET_VECTOR  : default fetch address after reset
//   fetch_entry_t : one buffered instruction {pc, instr}
//   align4        : clears the two low address bits
package leve1_if_pkg;

  localparam int unsigned     XLEN         = 32;
  localparam int unsigned     ILEN         = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/leve1_if_fifo.sv
// Instruction buffer for the fetch stage: synchronous FIFO of fetch_entry_t.
// Ports:
//   CLK, RSTn        clock / asynchronous active-low reset
//   i_push, i_data   write request and entry
//   i_pop            read request (head advances)
//   i_flush          empties the FIFO; overrides push and pop
//   o_head           current head entry (registered storage, no bypass)
//   o_full, o_empty  status flags
//   o_count          number of valid entries
module leve1_if_fifo
  import leve1_if_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic [CW-1:0] o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // A push into a full buffer is accepted only when the head leaves in the
  // same cycle; it then lands in the slot being vacated.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= next_ptr(r_wptr);
      if (w_do_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/leve1_if.sv
// LEVE1 instruction-fetch stage.
// Owns the fetch PC, issues in-order requests to instruction memory under a
// credit limit of FIFO_DEPTH (in-flight + buffered), buffers responses and
// presents them to decode with a valid/ready handshake. A redirect from
// execute reloads the PC, flushes the buffer and marks every in-flight
// response stale so it is dropped on return.
// Ports:
//   CLK, RSTn                   clock / asynchronous active-low reset
//   IMEM_REQ, IMEM_ADDR         fetch request and word-aligned address
//   IMEM_GNT                    request accepted
//   IMEM_RVALID, IMEM_RDATA     in-order response
//   REDIRECT, REDIRECT_PC       control-flow redirect and target
//   OVALID, OPC, OINSTR         instruction presented to decode
//   IREADY                      decode accepts the presented instruction
module leve1_if
  import leve1_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RSTn,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [ILEN-1:0] IMEM_RDATA,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            OVALID,
  output logic [XLEN-1:0] OPC,
  output logic [ILEN-1:0] OINSTR,
  input  logic            IREADY
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_credit_used;
  logic [CW-1:0]   w_out_nxt;
  logic            w_grant;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  fetch_entry_t    w_head;
  fetch_entry_t    w_wdata;

  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_count};
  assign IMEM_REQ      = RSTn && !REDIRECT && (w_credit_used < (CW + 1)'(FIFO_DEPTH));
  assign IMEM_ADDR     = r_pc;
  assign w_grant       = IMEM_REQ && IMEM_GNT;

  assign w_drop  = IMEM_RVALID && (r_discard != '0);
  assign w_push  = IMEM_RVALID && !w_drop && !REDIRECT;
  assign w_pop   = OVALID && IREADY;
  assign w_wdata = '{pc: r_rsp_pc, instr: IMEM_RDATA};

  always_comb begin
    w_out_nxt = r_outstanding;
    if (w_grant && !IMEM_RVALID) begin
      w_out_nxt = r_outstanding + 1'b1;
    end else if (!w_grant && IMEM_RVALID && (r_outstanding != '0)) begin
      w_out_nxt = r_outstanding - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (REDIRECT) begin
        r_pc      <= align4(REDIRECT_PC);
        r_rsp_pc  <= align4(REDIRECT_PC);
        // No grant is possible in a redirect cycle, so the post-edge
        // in-flight count is exactly the set of responses to drop.
        r_discard <= w_out_nxt;
      end else begin
        if (w_grant) r_pc <= r_pc + 32'd4;
        if (w_push)  r_rsp_pc <= r_rsp_pc + 32'd4;
        if (w_drop)  r_discard <= r_discard - 1'b1;
      end
    end
  end

  leve1_if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .i_push  (w_push),
    .i_data  (w_wdata),
    .i_pop   (w_pop),
    .i_flush (REDIRECT),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign OVALID = !w_empty;
  assign OPC    = w_head.pc;
  assign OINSTR = w_head.instr;

endmodule

// File: tb/tb_leve1_if.sv
module tb_leve1_if;
  import leve1_if_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        OVALID;
  logic [31:0] OPC;
  logic [31:0] OINSTR;
  logic        IREADY;

  always #5 CLK = ~CLK;

  leve1_if #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_GNT    (IMEM_GNT),
    .IMEM_RVALID (IMEM_RVALID),
    .IMEM_RDATA  (IMEM_RDATA),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .OVALID      (OVALID),
    .OPC         (OPC),
    .OINSTR      (OINSTR),
    .IREADY      (IREADY)
  );

  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  pend_t       pend_q[$];  // requests granted, response not yet returned
  exp_t        exp_q[$];   // scoreboard: instructions decode should see, in order
  logic [31:0] m_pc;
  bit          gnt_en, rsp_en, rdy, redir;
  logic [31:0] redir_pc;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check #1 later, update model at posedge.
  task automatic tick();
    bit    rv, req_seen, pop_now, exp_req, granted;
    pend_t rsp;
    rv          = rsp_en && (pend_q.size() != 0);
    IMEM_RVALID = rv;
    IMEM_RDATA  = rv ? instr_of(pend_q[0].addr) : 32'h0;
    IMEM_GNT    = gnt_en;
    REDIRECT    = redir;
    REDIRECT_PC = redir_pc;
    IREADY      = rdy;
    #1;
    exp_req = !redir && ((pend_q.size() + exp_q.size()) < DEPTH);
    chk("imem_req", 32'(IMEM_REQ), 32'(exp_req));
    req_seen = IMEM_REQ;
    if (exp_req) chk("imem_addr", IMEM_ADDR, m_pc);
    chk("ovalid", 32'(OVALID), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("opc", OPC, exp_q[0].pc);
      chk("oinstr", OINSTR, exp_q[0].instr);
    end
    pop_now = (exp_q.size() != 0) && rdy && !redir;
    @(posedge CLK);
    granted = req_seen && gnt_en;
    if (pop_now) void'(exp_q.pop_front());
    if (rv) begin
      rsp = pend_q.pop_front();
      if (!rsp.stale && !redir) begin
        checks++;
        assert (exp_q.size() < DEPTH) else begin
          errors++;
          $error("FAIL fifo_overflow: observed %0d entries expected < %0d", exp_q.size(), DEPTH);
        end
        exp_q.push_back('{rsp.addr, instr_of(rsp.addr)});
      end
    end
    if (redir) begin
      exp_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      m_pc = redir_pc & ~32'h3;
    end else if (granted) begin
      pend_q.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    @(negedge CLK);
  endtask

  // Entered at a negedge; late responses are presented while reset is held.
  task automatic do_reset(input int cycles);
    RSTn = 1'b0;
    #1;
    chk("rst_ovalid", 32'(OVALID), 32'd0);
    chk("rst_req", 32'(IMEM_REQ), 32'd0);
    IMEM_GNT = 1'b1;
    IREADY   = 1'b1;
    REDIRECT = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      IMEM_RVALID = (i < 2);
      IMEM_RDATA  = 32'hDEAD_0000 + 32'(i);
      @(posedge CLK);
      #1;
      chk("rst_req_hold", 32'(IMEM_REQ), 32'd0);
      chk("rst_ovalid_hold", 32'(OVALID), 32'd0);
      @(negedge CLK);
    end
    IMEM_RVALID = 1'b0;
    pend_q.delete();
    exp_q.delete();
    m_pc = RPC;
    RSTn = 1'b1;
  endtask

  initial begin
    RSTn        = 1'b0;
    IMEM_GNT    = 1'b0;
    IMEM_RVALID = 1'b0;
    IMEM_RDATA  = '0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = '0;
    IREADY      = 1'b0;
    redir       = 1'b0;
    redir_pc    = '0;
    m_pc        = RPC;
    @(negedge CLK);
    do_reset(3);

    // Streaming from RESET_PC with eager memory and decode.
    gnt_en = 1'b1;
    rsp_en = 1'b1;
    rdy    = 1'b1;
    repeat (10) tick();

    // Decode backpressure, then release.
    rdy = 1'b0;
    repeat (6) tick();
    rdy = 1'b1;
    repeat (6) tick();

    // Two requests in flight at 0x200/0x204, then redirect to 0x300.
    redir = 1'b1; redir_pc = 32'h0000_0200; tick();
    redir = 1'b0; rsp_en = 1'b0;
    repeat (3) tick();
    chk("inflight_before_redirect", 32'(pend_q.size()), 32'd2);
    redir = 1'b1; redir_pc = 32'h0000_0300; tick();
    redir = 1'b0; rsp_en = 1'b1;
    repeat (8) tick();

    // Redirect colliding with a response and a pop; unaligned target.
    for (int n = 0; n < 20 && !(pend_q.size() != 0 && exp_q.size() != 0); n++) tick();
    checks++;
    assert (pend_q.size() != 0 && exp_q.size() != 0) else begin
      errors++;
      $error("FAIL collision_setup: observed pend=%0d fifo=%0d expected both nonzero",
             pend_q.size(), exp_q.size());
    end
    redir = 1'b1; redir_pc = 32'h0000_0403; tick();
    redir = 1'b0;
    repeat (6) tick();

    // PC wrap-around.
    redir = 1'b1; redir_pc = 32'hFFFF_FFF8; tick();
    redir = 1'b0;
    repeat (8) tick();

    // Reset mid-stream with a full buffer and responses in flight.
    rdy = 1'b0;
    repeat (5) tick();
    do_reset(3);
    rdy = 1'b1;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
